// File: rtl/comb_bank_sequencer.sv
// Time-multiplexed bank of NCOMB feedback comb filters sharing one delay-line RAM.
// Optional macro COMB_SATURATE_EN clamps the feedback sum instead of wrapping it.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module comb_bank_sequencer #(
    parameter int WIDTH    = 24,
    parameter int NCOMB    = 4,
    parameter int MAXDELAY = 4096,
    localparam int WORD    = WIDTH + `FIXED_POINT,
    localparam int ADDR    = $clog2(NCOMB * MAXDELAY),
    localparam int TAUW    = $clog2(MAXDELAY + 1)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              sample_tick,
    input  logic signed [WORD-1:0]            in,
    input  logic        [NCOMB-1:0][TAUW-1:0] tau,
    input  logic        [NCOMB-1:0][WORD-1:0] gain,
    output logic        [ADDR-1:0]            mem_addr,
    output logic                              mem_we,
    output logic        [WORD-1:0]            mem_wdata,
    input  logic        [WORD-1:0]            mem_rdata,
    output logic signed [WORD-1:0]            out,
    output logic                              out_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int LOG2N = $clog2(NCOMB);
    localparam int CHW   = (NCOMB > 1) ? LOG2N : 1;
    localparam int ACCW  = WORD + LOG2N;
    localparam logic [TAUW-1:0] MAXD = TAUW'(MAXDELAY);

    typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_t;

    state_t                  state_reg;
    logic [CHW-1:0]          ch_reg;
    logic [TAUW-1:0]         wp_reg [NCOMB];
    logic signed [WORD-1:0]  y_reg [NCOMB];
    logic signed [WORD-1:0]  in_reg;
    logic signed [ACCW-1:0]  acc_reg;

    logic [TAUW-1:0]         teff [NCOMB];
    logic signed [2*WORD-1:0] prod;
    logic signed [WORD-1:0]  fb;
    logic signed [WORD-1:0]  wr_value;
    logic signed [ACCW-1:0]  acc_next;
    logic [TAUW-1:0]         wp_inc;
    logic [CHW-1:0]          ch_next;
    logic [ADDR-1:0]         next_addr;
    logic                    last_ch;

    // Effective delay: 0 behaves as 1, anything past the region depth is clamped.
    generate
        for (genvar gi = 0; gi < NCOMB; gi++) begin : g_teff
            assign teff[gi] = (tau[gi] == '0) ? TAUW'(1) :
                              (tau[gi] > MAXD) ? MAXD : tau[gi];
        end
    endgenerate

    always_comb begin
        prod      = $signed(gain[ch_reg]) * $signed(mem_rdata);
        fb        = WORD'(prod >>> `FIXED_POINT);
`ifdef COMB_SATURATE_EN
        begin
            logic signed [WORD:0] sum_ext;
            sum_ext = {in_reg[WORD-1], in_reg} + {fb[WORD-1], fb};
            if (sum_ext[WORD] != sum_ext[WORD-1])
                wr_value = sum_ext[WORD] ? {1'b1, {(WORD-1){1'b0}}} : {1'b0, {(WORD-1){1'b1}}};
            else
                wr_value = sum_ext[WORD-1:0];
        end
`else
        wr_value  = in_reg + fb;
`endif
        acc_next  = acc_reg + ACCW'(y_reg[ch_reg]);
        wp_inc    = wp_reg[ch_reg] + TAUW'(1);
        ch_next   = ch_reg + CHW'(1);
        next_addr = ADDR'(ch_next) * ADDR'(MAXDELAY) + ADDR'(wp_reg[ch_next]);
        last_ch   = (ch_reg == CHW'(NCOMB - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
            in_reg    <= '0;
            acc_reg   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NCOMB; i++) begin
                wp_reg[i] <= '0;
                y_reg[i]  <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            mem_we    <= 1'b0;
            // Any tick outside IDLE, including the DONE cycle, is dropped.
            if (sample_tick && state_reg != IDLE)
                overrun <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (sample_tick) begin
                        in_reg    <= in;
                        ch_reg    <= '0;
                        acc_reg   <= '0;
                        mem_addr  <= ADDR'(wp_reg[0]);
                        busy      <= 1'b1;
                        state_reg <= RD;
                    end
                end
                RD: state_reg <= CALC;
                CALC: begin
                    // Write data is formed from the live read word so it is ready as WR begins.
                    y_reg[ch_reg] <= mem_rdata;
                    mem_wdata     <= wr_value;
                    mem_we        <= 1'b1;
                    state_reg     <= WR;
                end
                WR: begin
                    wp_reg[ch_reg] <= (wp_inc >= teff[ch_reg]) ? '0 : wp_inc;
                    acc_reg        <= acc_next;
                    if (last_ch) begin
                        out       <= WORD'(acc_next >>> LOG2N);
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        ch_reg    <= ch_next;
                        mem_addr  <= next_addr;
                        state_reg <= RD;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_bank_sequencer.sv
// Scoreboard bench for comb_bank_sequencer: directed frames push expected outputs,
// a negedge monitor pops them on out_valid and range-checks every RAM write.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module tb_comb_bank_sequencer;

    localparam int WIDTH    = 24;
    localparam int NCOMB    = 4;
    localparam int MAXDELAY = 16;
    localparam int WORD     = WIDTH + `FIXED_POINT;
    localparam int ADDR     = $clog2(NCOMB * MAXDELAY);
    localparam int TAUW     = $clog2(MAXDELAY + 1);

    localparam logic [WORD-1:0] WMAX = {1'b0, {(WORD-1){1'b1}}};
`ifdef COMB_SATURATE_EN
    localparam logic [WORD-1:0] SAT_EXP = {1'b0, {(WORD-1){1'b1}}};
`else
    localparam logic [WORD-1:0] SAT_EXP = {{(WORD-1){1'b1}}, 1'b0};
`endif

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        sample_tick;
    logic signed [WORD-1:0]      din;
    logic [NCOMB-1:0][TAUW-1:0]  tau;
    logic [NCOMB-1:0][WORD-1:0]  gain;
    logic [ADDR-1:0]             mem_addr;
    logic                        mem_we;
    logic [WORD-1:0]             mem_wdata;
    logic [WORD-1:0]             mem_rdata;
    logic signed [WORD-1:0]      out;
    logic                        out_valid;
    logic                        busy;
    logic                        overrun;

    logic [WORD-1:0] ram [NCOMB*MAXDELAY];
    logic            ram_clr;
    logic [WORD-1:0] exp_q [$];
    logic [WORD-1:0] mon_exp;
    int              teff_exp [NCOMB];
    int              n_cmp = 0;
    int              n_err = 0;
    int              n_out = 0;

    comb_bank_sequencer #(.WIDTH(WIDTH), .NCOMB(NCOMB), .MAXDELAY(MAXDELAY)) dut (
        .clk(clk), .rstn(rstn), .sample_tick(sample_tick), .in(din),
        .tau(tau), .gain(gain), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .out(out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < NCOMB*MAXDELAY; i++) ram[i] <= '0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per out_valid and bounds every write to its channel region.
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got out=%0d with no pending frame", out);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("frame %0d: out=%0d expected=%0d", n_out, out, $signed(mon_exp));
                check("out", out, mon_exp);
            end
        end
        if (rstn && mem_we)
            check_bit("wr_in_region",
                      (int'(mem_addr) % MAXDELAY) < teff_exp[int'(mem_addr) / MAXDELAY], 1'b1);
    end

    task automatic set_cfg(input int t0, input int t1, input int t2, input int t3,
                           input logic [WORD-1:0] g, input int e0, input int e1,
                           input int e2, input int e3);
        tau = {TAUW'(t3), TAUW'(t2), TAUW'(t1), TAUW'(t0)};
        for (int i = 0; i < NCOMB; i++) gain[i] = g;
        teff_exp = '{e0, e1, e2, e3};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        ram_clr = 1'b1;
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ram_clr = 1'b0;
        @(negedge clk);
        check("queue_drained", WORD'(exp_q.size()), '0);
        check_bit("overrun_cleared", overrun, 1'b0);
        check_bit("busy_cleared", busy, 1'b0);
    endtask

    task automatic run_frame(input logic [WORD-1:0] d, input logic [WORD-1:0] exp);
        @(negedge clk);
        sample_tick = 1'b1;
        din = d;
        exp_q.push_back(exp);
        @(negedge clk);
        sample_tick = 1'b0;
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_timeout: got busy=1 expected busy=0 within 40 cycles");
        end
    endtask

    // Second tick t2 cycles after the first must be dropped and flag overrun.
    task automatic overrun_run(input int t2, input logic [WORD-1:0] d, input logic [WORD-1:0] exp);
        int seen;
        seen = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        din = d;
        exp_q.push_back(exp);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                sample_tick = 1'b0;
                check_bit("busy_in_frame", busy, 1'b1);
            end
            if (out_valid && seen == 0) seen = n;
            if (n == t2) begin
                check_bit("overrun_before", overrun, 1'b0);
                sample_tick = 1'b1;
            end
            if (n == t2 + 1) begin
                sample_tick = 1'b0;
                check_bit("overrun_after", overrun, 1'b1);
            end
        end
        check("latency", WORD'(seen), WORD'(13));
        check_bit("busy_after_overrun", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int imp_exp [12];
        int fb_exp [9];
        rstn = 1'b0;
        ram_clr = 1'b1;
        sample_tick = 1'b0;
        din = '0;
        set_cfg(1, 1, 1, 1, '0, 1, 1, 1, 1);
        repeat (3) @(negedge clk);
        check("rst_out", out, '0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_overrun", overrun, 1'b0);
        check_bit("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", WORD'(mem_addr), '0);
        check("rst_mem_wdata", mem_wdata, '0);
        rstn = 1'b1;
        ram_clr = 1'b0;

        // Impulse: echoes of 256 at ticks 3,5,7,11, each worth 256/4 on out.
        do_reset();
        set_cfg(3, 5, 7, 11, '0, 3, 5, 7, 11);
        imp_exp = '{0, 0, 0, 64, 0, 64, 0, 64, 0, 0, 0, 64};
        for (int k = 0; k < 12; k++)
            run_frame((k == 0) ? WORD'(256) : '0, WORD'(imp_exp[k]));
        repeat (5) @(negedge clk);
        check("out_hold", out, WORD'(64));

        // Feedback 0.5 with tau=2: echoes decay 256,128,64,32 every second tick.
        do_reset();
        set_cfg(2, 2, 2, 2, WORD'(128), 2, 2, 2, 2);
        fb_exp = '{0, 0, 256, 0, 128, 0, 64, 0, 32};
        for (int k = 0; k < 9; k++)
            run_frame((k == 0) ? WORD'(256) : '0, WORD'(fb_exp[k]));

        // Overrun mid-frame and in the DONE cycle.
        do_reset();
        set_cfg(1, 1, 1, 1, '0, 1, 1, 1, 1);
        run_frame(WORD'(400), '0);
        overrun_run(5, '0, WORD'(400));
        do_reset();
        overrun_run(13, '0, '0);

        // Reset during WR of channel 2: channels 0,1 hold 100, channel 2 was never written.
        do_reset();
        set_cfg(4, 4, 4, 4, '0, 4, 4, 4, 4);
        @(negedge clk);
        sample_tick = 1'b1;
        din = WORD'(100);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) sample_tick = 1'b0;
        end
        check_bit("we_in_wr2", mem_we, 1'b1);
        check("addr_in_wr2", WORD'(mem_addr), WORD'(2*MAXDELAY));
        rstn = 1'b0;
        #1;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_we", mem_we, 1'b0);
        check_bit("abort_out_valid", out_valid, 1'b0);
        check("abort_out", out, '0);
        check("abort_addr", WORD'(mem_addr), '0);
        check("abort_wdata", mem_wdata, '0);
        repeat (2) begin
            @(negedge clk);
            check_bit("we_held_in_reset", mem_we, 1'b0);
        end
        rstn = 1'b1;
        @(negedge clk);
        sample_tick = 1'b1;
        din = '0;
        exp_q.push_back(WORD'(50));
        @(negedge clk);
        sample_tick = 1'b0;
        check("first_rd_addr", WORD'(mem_addr), '0);
        check_bit("first_rd_we", mem_we, 1'b0);
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);

        // tau=0 acts as 1 and tau=31 acts as MAXDELAY.
        do_reset();
        set_cfg(0, 31, 1, 16, '0, 1, 16, 1, 16);
        for (int k = 0; k < 17; k++)
            run_frame((k == 0) ? WORD'(256) : '0, (k == 1 || k == 16) ? WORD'(128) : '0);

        // max + 1.0*max in the feedback sum.
        do_reset();
        set_cfg(1, 1, 1, 1, WORD'(256), 1, 1, 1, 1);
        run_frame(WMAX, '0);
        run_frame(WMAX, WMAX);
        run_frame('0, SAT_EXP);

        repeat (5) @(negedge clk);
        check("queue_drained_end", WORD'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
